// File: rtl/branch_cond_unit.sv
// branch_cond_unit: evaluates one of eight branch conditions on two register
// operands, registers the PC write enable and the taken flag, and keeps
// saturating counters of evaluated and taken branches.
module branch_cond_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             eval,
    input  logic             pc_write_uncond,
    input  logic [2:0]       cond_sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             taken,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0] SEL_NE  = 3'b000;
    localparam logic [2:0] SEL_EQ  = 3'b001;
    localparam logic [2:0] SEL_GT  = 3'b010;
    localparam logic [2:0] SEL_LE  = 3'b011;
    localparam logic [2:0] SEL_LT  = 3'b100;
    localparam logic [2:0] SEL_GE  = 3'b101;
    localparam logic [2:0] SEL_LTU = 3'b110;

    logic             cond;
    logic             eq;
    logic             lt_s;
    logic             lt_u;
    logic             pc_write_reg;
    logic             pc_write_next;
    logic             taken_reg;
    logic             taken_next;
    logic [1:0]       cnt_inc;
    logic [1:0][CNT_W-1:0] cnt_all;

    // Native signed/unsigned comparators: no subtract-and-test-sign, so no
    // overflow artefacts at the most-negative/most-positive boundary.
    assign eq   = (op_a == op_b);
    assign lt_s = ($signed(op_a) < $signed(op_b));
    assign lt_u = (op_a < op_b);

    // Condition decode from the selected comparison.
    always_comb begin
        cond = 1'b1;
        case (cond_sel)
            SEL_NE:  cond = ~eq;
            SEL_EQ:  cond = eq;
            SEL_GT:  cond = ~lt_s & ~eq;
            SEL_LE:  cond = lt_s | eq;
            SEL_LT:  cond = lt_s;
            SEL_GE:  cond = ~lt_s;
            SEL_LTU: cond = lt_u;
            default: cond = 1'b1;
        endcase
    end

    // Next PC-write pulse and taken flag; taken holds outside eval cycles,
    // and gating by eval keeps don't-care operands from reaching the flops.
    always_comb begin
        pc_write_next = pc_write_uncond | (eval & cond);
        taken_next    = taken_reg;
        if (eval) begin
            taken_next = cond;
        end
    end

    // Output flops; reset overrides every input of the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_write_reg <= 1'b0;
            taken_reg    <= 1'b0;
        end else begin
            pc_write_reg <= pc_write_next;
            taken_reg    <= taken_next;
        end
    end

    // Counter 0 counts evaluations, counter 1 counts taken evaluations.
    // Taken only increments alongside an evaluation, so taken <= evaluated.
    assign cnt_inc = {eval & cond, eval};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;

        // Saturating increment; clear wins over a same-cycle increment.
        always_comb begin
            cnt_next = cnt_reg;
            if (cnt_clear) begin
                cnt_next = '0;
            end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_next = cnt_reg + 1'b1;
            end
        end

        // Counter register with synchronous reset.
        always_ff @(posedge clock) begin
            if (reset) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end

        assign cnt_all[gi] = cnt_reg;
    end

    assign pc_write     = pc_write_reg;
    assign taken        = taken_reg;
    assign branch_count = cnt_all[0];
    assign taken_count  = cnt_all[1];

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Parametrised successor to the multicycle PC-write condition selector.
- Compares two register operands directly rather than selecting pre-computed flag wires, and supports eight branch conditions.
- Registers the PC write decision.
- Keeps saturating branch-evaluated and branch-taken counters for debug and performance readout.
- Sits between the control unit (PCWriteCond/PCWrite, condition select) and the PC register write enable.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- CNT_W, 16, width of each statistics counter (>=1).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- eval  input  1  control asserts conditional PC write (PCWriteCond) this cycle.
- pc_write_uncond  input  1  control asserts unconditional PC write (PCWrite) this cycle.
- cond_sel  input  3  branch condition select, sampled only when eval=1.
- op_a  input  WIDTH  first operand (rs).
- op_b  input  WIDTH  second operand (rt, or zero for compare-with-zero branches).
- cnt_clear  input  1  synchronous clear of both statistics counters.
- pc_write  output  1  registered PC write enable.
- taken  output  1  registered; 1 if the last evaluated branch was taken.
- branch_count  output  CNT_W  number of eval cycles, saturating.
- taken_count  output  CNT_W  number of taken branches, saturating.

Behaviour:
- Condition decode (combinational, internal):
  - 000 NE: op_a != op_b
  - 001 EQ: op_a == op_b
  - 010 GT: signed op_a > op_b
  - 011 LE: signed op_a <= op_b
  - 100 LT: signed op_a < op_b
  - 101 GE: signed op_a >= op_b
  - 110 LTU: unsigned op_a < op_b
  - 111 ALWAYS: 1
- Signed compares treat both operands as two's complement WIDTH-bit values. No overflow artefacts: compare sign-correctly, never by subtract-and-test-sign.
- Latency: all outputs are registered, one cycle.
  - pc_write(t+1) = pc_write_uncond(t) | (eval(t) & cond(t)).
  - taken updates only on eval cycles: taken(t+1) = cond(t) if eval(t)=1; otherwise taken holds.
- pc_write is a one-cycle pulse per qualifying input cycle. It does not stretch, and it is not held.
- eval and pc_write_uncond both high: pc_write=1. taken still reflects cond. Counters still count the eval.
- Counters:
  - On eval=1: branch_count += 1; taken_count += 1 if cond=1.
  - Each counter saturates at all-ones (2^CNT_W-1) and never wraps.
  - taken_count <= branch_count always holds.
- cnt_clear=1: both counters become 0 next cycle. This has priority over an eval in the same cycle, and that eval is not counted. pc_write and taken still update normally in that cycle.
- reset=1: next edge sets pc_write=0, taken=0, branch_count=0, taken_count=0. All inputs that cycle are ignored.
  - Reset asserted in the cycle after eval: the pending pc_write pulse appears, because it is already registered. The following edge clears everything.
  - Reset asserted together with eval: no pulse, no count.
- cond_sel and operands are don't-care when eval=0. X on them must not propagate to any output.
- No other state exists and no FSM beyond the registers above. Outputs are glitch-free because they come straight from flops.

Test Plan:
- Reset then idle 5 cycles -> pc_write=0, taken=0, branch_count=0, taken_count=0 throughout.
- Signed boundary, WIDTH=32, single eval cycles:
  - op_a=0x80000000, op_b=0x7FFFFFFF, cond_sel=100 (LT) -> next cycle pc_write=1, taken=1.
  - Same operands, cond_sel=110 (LTU) -> pc_write=0, taken=0.
  - cond_sel=010 (GT) with op_a=op_b=5 -> taken=0.
  - cond_sel=101 (GE) with op_a=op_b=5 -> taken=1.
- EQ/NE sweep: op_a=op_b=0x1234, eval cycles with 001 then 000 -> pc_write pulses 1 then 0.
  - branch_count=2, taken_count=1.
  - pc_write_uncond=1 with eval=0 -> pc_write=1, counts unchanged.
- Saturation, CNT_W=3: 10 consecutive eval cycles with cond_sel=111 -> both counters reach 7 and hold at 7.
  - Then cnt_clear with simultaneous eval -> counters=0 next cycle, pc_write=1.
- Reset mid-operation: eval with taken branch at cycle N, reset at N+1 -> pc_write=1 at N+1 edge output, all outputs 0 after N+2 edge.
  - eval and reset in the same cycle -> no pulse, counters remain 0.
